// File: rtl/arb_pkg.sv
// Shared definitions for the decoder-sharing round-robin arbiter.
// Holds the requester/index/counter widths, the FSM state type and a one-hot helper.
package arb_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned HOLD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping.
// The index arithmetic is modulo 2**IDX_W, so ptr+N_REQ lands back on ptr itself.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!any && eligible[idx]) begin
        win_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_grant_arbiter.sv
// Round-robin owner of a shared 3-to-8 decoder with hold timeout, lockout and
// a one-cycle break-before-make gap on every ownership change.
module dec_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 255
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel_i,
  output logic             sel_en,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_nxt;
  logic [IDX_W-1:0]  ptr_q, ptr_nxt;
  logic [N_REQ-1:0]  lock_q, lock_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;
  logic [IDX_W-1:0]  sel_i_nxt;
  logic              sel_en_nxt, busy_nxt, timeout_nxt;
  logic [N_REQ-1:0]  gnt_nxt;

  logic [N_REQ-1:0]  eligible;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;

  assign eligible = req & ~lock_q;

  rr_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .win_idx  (win_idx),
    .any      (win_any)
  );

  always_comb begin
    state_nxt   = state_q;
    ptr_nxt     = ptr_q;
    hold_nxt    = hold_q;
    sel_i_nxt   = sel_i;
    sel_en_nxt  = 1'b0;
    gnt_nxt     = '0;
    busy_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    // Locks only clear on a low request, so clearing and setting never collide.
    lock_nxt    = lock_q & req;

    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_any) begin
          state_nxt  = ST_GRANT;
          sel_i_nxt  = win_idx;
          ptr_nxt    = win_idx;
          hold_nxt   = '0;
          sel_en_nxt = 1'b1;
          gnt_nxt    = onehot(win_idx);
          busy_nxt   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        hold_nxt = hold_q + HOLD_W'(1);
        busy_nxt = 1'b1;
        if (!req[sel_i]) begin
          state_nxt = ST_GAP;
        end else if (hold_q == HOLD_LAST) begin
          state_nxt   = ST_GAP;
          timeout_nxt = 1'b1;
          lock_nxt    = (lock_q & req) | onehot(sel_i);
        end else begin
          sel_en_nxt = 1'b1;
          gnt_nxt    = onehot(sel_i);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      lock_q  <= '0;
      hold_q  <= '0;
      sel_i   <= '0;
      sel_en  <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      lock_q  <= lock_nxt;
      hold_q  <= hold_nxt;
      sel_i   <= sel_i_nxt;
      sel_en  <= sel_en_nxt;
      gnt     <= gnt_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule
